// File: rtl/zap_tlb_walker.sv
// zap_tlb_walker
// Page-table walker for the MMU. When the TLB checker reports a miss, it reads the
// ARMv5 L1 descriptor and, for coarse or fine tables, the L2 descriptor. The reads go
// over a Wishbone-classic read master. The walk ends in one TLB write pulse
// (section/small/large/fine) or in a translation fault.
//
// Ports
//   i_clk, i_reset_n         clock, asynchronous active-low reset
//   i_walk, i_va, i_ttb      walk request (level), missing VA, table base [31:14]
//   o_busy                   walker not idle
//   o_wb_cyc/stb/adr         Wishbone read master (stb mirrors cyc)
//   i_wb_ack, i_wb_dat       Wishbone acknowledge and read data
//   o_*tlb_wen               one-cycle TLB write strobes
//   o_tlb_va/l1/l2           latched VA and descriptors feeding the TLB RAMs
//   o_done, o_fault          walk finished / translation fault (one-cycle pulses)
//   o_fsr, o_far             fault status {domain, status} and fault address
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for i_walk
// FETCH_L1  | L1 descriptor read in flight
// FETCH_L2  | L2 descriptor read in flight
// DONE      | result decided; pulse wen or fault together with done
// HOLD      | one dead cycle so the requester can drop i_walk

module zap_tlb_walker (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_walk,
   input  logic [31:0] i_va,
   input  logic [31:0] i_ttb,
   output logic        o_busy,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic [31:0] o_wb_adr,
   input  logic        i_wb_ack,
   input  logic [31:0] i_wb_dat,
   output logic        o_setlb_wen,
   output logic        o_sptlb_wen,
   output logic        o_lptlb_wen,
   output logic        o_fptlb_wen,
   output logic [31:0] o_tlb_va,
   output logic [31:0] o_tlb_l1,
   output logic [31:0] o_tlb_l2,
   output logic        o_done,
   output logic        o_fault,
   output logic [7:0]  o_fsr,
   output logic [31:0] o_far
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH_L1,
      ST_FETCH_L2,
      ST_DONE,
      ST_HOLD
   } state_t;

   typedef enum logic [2:0] {
      RES_FAULT,
      RES_SECT,
      RES_SMALL,
      RES_LARGE,
      RES_FINE
   } result_t;

   state_t      state, state_nxt;
   result_t     result, result_nxt;
   logic [7:0]  fsr_pend, fsr_pend_nxt;
   logic        busy_nxt, cyc_nxt;
   logic [31:0] adr_nxt, va_nxt, l1_nxt, l2_nxt;
   logic        setlb_nxt, sptlb_nxt, lptlb_nxt, fptlb_nxt;
   logic        done_nxt, fault_nxt;
   logic [7:0]  fsr_nxt;

   // Only the 16 KB-aligned part of the table base is meaningful.
   logic unused_ttb_bits;
   assign unused_ttb_bits = ^i_ttb[13:0];

   // Both are straight copies of registers, so they stay glitch-free.
   assign o_wb_stb = o_wb_cyc;
   assign o_far    = o_tlb_va;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state       <= ST_IDLE;
         result      <= RES_FAULT;
         fsr_pend    <= '0;
         o_busy      <= 1'b0;
         o_wb_cyc    <= 1'b0;
         o_wb_adr    <= '0;
         o_tlb_va    <= '0;
         o_tlb_l1    <= '0;
         o_tlb_l2    <= '0;
         o_setlb_wen <= 1'b0;
         o_sptlb_wen <= 1'b0;
         o_lptlb_wen <= 1'b0;
         o_fptlb_wen <= 1'b0;
         o_done      <= 1'b0;
         o_fault     <= 1'b0;
         o_fsr       <= '0;
      end else begin
         state       <= state_nxt;
         result      <= result_nxt;
         fsr_pend    <= fsr_pend_nxt;
         o_busy      <= busy_nxt;
         o_wb_cyc    <= cyc_nxt;
         o_wb_adr    <= adr_nxt;
         o_tlb_va    <= va_nxt;
         o_tlb_l1    <= l1_nxt;
         o_tlb_l2    <= l2_nxt;
         o_setlb_wen <= setlb_nxt;
         o_sptlb_wen <= sptlb_nxt;
         o_lptlb_wen <= lptlb_nxt;
         o_fptlb_wen <= fptlb_nxt;
         o_done      <= done_nxt;
         o_fault     <= fault_nxt;
         o_fsr       <= fsr_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      result_nxt   = result;
      fsr_pend_nxt = fsr_pend;
      cyc_nxt      = o_wb_cyc;
      adr_nxt      = o_wb_adr;
      va_nxt       = o_tlb_va;
      l1_nxt       = o_tlb_l1;
      l2_nxt       = o_tlb_l2;
      fsr_nxt      = o_fsr;
      setlb_nxt    = 1'b0;
      sptlb_nxt    = 1'b0;
      lptlb_nxt    = 1'b0;
      fptlb_nxt    = 1'b0;
      done_nxt     = 1'b0;
      fault_nxt    = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (i_walk) begin
               va_nxt    = i_va;
               l1_nxt    = '0;
               l2_nxt    = '0;
               cyc_nxt   = 1'b1;
               adr_nxt   = {i_ttb[31:14], i_va[31:20], 2'b00};
               state_nxt = ST_FETCH_L1;
            end
         end

         ST_FETCH_L1: begin
            if (i_wb_ack) begin
               l1_nxt = i_wb_dat;
               unique case (i_wb_dat[1:0])
                  2'b10: begin
                     result_nxt = RES_SECT;
                     cyc_nxt    = 1'b0;
                     state_nxt  = ST_DONE;
                  end
                  2'b00: begin
                     result_nxt   = RES_FAULT;
                     fsr_pend_nxt = {i_wb_dat[8:5], 4'h5};
                     cyc_nxt      = 1'b0;
                     state_nxt    = ST_DONE;
                  end
                  // Coarse and fine tables chain straight into the L2 read
                  // without dropping the bus cycle.
                  2'b01: begin
                     adr_nxt   = {i_wb_dat[31:10], o_tlb_va[19:12], 2'b00};
                     state_nxt = ST_FETCH_L2;
                  end
                  default: begin
                     adr_nxt   = {i_wb_dat[31:12], o_tlb_va[19:10], 2'b00};
                     state_nxt = ST_FETCH_L2;
                  end
               endcase
            end
         end

         ST_FETCH_L2: begin
            if (i_wb_ack) begin
               l2_nxt       = i_wb_dat;
               cyc_nxt      = 1'b0;
               state_nxt    = ST_DONE;
               fsr_pend_nxt = {o_tlb_l1[8:5], 4'h7};
               unique case (i_wb_dat[1:0])
                  2'b01:   result_nxt = RES_LARGE;
                  2'b10:   result_nxt = RES_SMALL;
                  // Tiny pages are only legal under a fine L1 table.
                  2'b11:   result_nxt = (o_tlb_l1[1:0] == 2'b11) ? RES_FINE : RES_FAULT;
                  default: result_nxt = RES_FAULT;
               endcase
            end
         end

         ST_DONE: begin
            done_nxt  = 1'b1;
            state_nxt = ST_HOLD;
            unique case (result)
               RES_SECT:  setlb_nxt = 1'b1;
               RES_SMALL: sptlb_nxt = 1'b1;
               RES_LARGE: lptlb_nxt = 1'b1;
               RES_FINE:  fptlb_nxt = 1'b1;
               default: begin
                  fault_nxt = 1'b1;
                  fsr_nxt   = fsr_pend;
               end
            endcase
         end

         ST_HOLD: begin
            state_nxt = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
            cyc_nxt   = 1'b0;
         end
      endcase

      busy_nxt = (state_nxt != ST_IDLE);
   end

endmodule
